// File: rtl/gray_chk_pkg.sv
// Shared types and helpers for 3-bit Gray-code sequence monitors.
package gray_chk_pkg;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } chk_state_e;

    localparam int LAP_STEPS = 8;

    function automatic logic [2:0] gray2bin3(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[2] ^ g[1];
        b[0] = g[2] ^ g[1] ^ g[0];
        return b;
    endfunction

endpackage

// File: rtl/gray_to_bin3.sv
// Combinational 3-bit Gray to binary decode, shareable by other monitors.
module gray_to_bin3
    import gray_chk_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [2:0] bin_o
);

    assign bin_o = gray2bin3({a, b, c});

endmodule

// File: rtl/gray_sequence_checker.sv
// Monitor for the 3-bit Gray stimulus cycle: tracks legal +/-1 steps,
// counts completed upward laps and illegal transitions.
module gray_sequence_checker
    import gray_chk_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int LAP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic [2:0]       bin,
    output logic             dir,
    output logic             step_ok,
    output logic             err,
    output logic             lap_done,
    output logic             in_sync,
    output logic [ERR_W-1:0] err_count,
    output logic [LAP_W-1:0] lap_count
);

    chk_state_e       state_q;
    logic [2:0]       last_q;
    logic [3:0]       run_q;
    logic [2:0]       bin_q;
    logic             dir_q;
    logic             step_ok_q;
    logic             err_q;
    logic             lap_done_q;
    logic [ERR_W-1:0] err_count_q;
    logic [LAP_W-1:0] lap_count_q;

    logic [2:0]       code_bin;
    logic [2:0]       delta_d;
    logic [3:0]       run_d;

    gray_to_bin3 u_dec (
        .a     (a),
        .b     (b),
        .c     (c),
        .bin_o (code_bin)
    );

    // Step distance around the 8-entry cycle; 1 = up, 7 = down.
    assign delta_d = code_bin - last_q;
    assign run_d   = run_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            last_q      <= '0;
            run_q       <= '0;
            bin_q       <= '0;
            dir_q       <= 1'b0;
            step_ok_q   <= 1'b0;
            err_q       <= 1'b0;
            lap_done_q  <= 1'b0;
            err_count_q <= '0;
            lap_count_q <= '0;
        end else begin
            step_ok_q  <= 1'b0;
            err_q      <= 1'b0;
            lap_done_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    TRACK: begin
                        case (delta_d)
                            3'd0: ;
                            3'd1: begin
                                step_ok_q <= 1'b1;
                                dir_q     <= 1'b1;
                                bin_q     <= code_bin;
                                last_q    <= code_bin;
                                // A lap only counts after eight uninterrupted up steps.
                                if (code_bin == 3'd0 && run_d == 4'(LAP_STEPS)) begin
                                    lap_done_q  <= 1'b1;
                                    lap_count_q <= lap_count_q + LAP_W'(1);
                                    run_q       <= '0;
                                end else begin
                                    run_q <= run_d;
                                end
                            end
                            3'd7: begin
                                step_ok_q <= 1'b1;
                                dir_q     <= 1'b0;
                                bin_q     <= code_bin;
                                last_q    <= code_bin;
                                run_q     <= '0;
                            end
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= FAULT;
                                if (err_count_q != '1)
                                    err_count_q <= err_count_q + ERR_W'(1);
                            end
                        endcase
                    end
                    default: begin
                        if (code_bin == 3'd0) begin
                            state_q <= TRACK;
                            last_q  <= '0;
                            run_q   <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign bin       = bin_q;
    assign dir       = dir_q;
    assign step_ok   = step_ok_q;
    assign err       = err_q;
    assign lap_done  = lap_done_q;
    assign in_sync   = (state_q == TRACK);
    assign err_count = err_count_q;
    assign lap_count = lap_count_q;

endmodule

// File: doc/gray_sequence_checker.md
# gray_sequence_checker

Receiving end of the 3-bit Gray-code stimulus sequence (000→001→011→010→110→111→101→100→000) that drives the switch-level gate tests. The block samples the 3-bit code `a b c` on a strobe and converts it to binary. It checks that every change is a single legal ±1 step around the Gray cycle, counts completed upward laps, and counts illegal transitions. It sits beside the device under test as a self-checking monitor.

## Interface
Parameters:
- `ERR_W`, 8, width of the saturating error counter
- `LAP_W`, 8, width of the wrapping lap counter

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `in_valid`  in  1  sample strobe. The code is evaluated only on cycles where this is 1.
- `a`  in  1  Gray MSB.
- `b`  in  1  Gray middle bit.
- `c`  in  1  Gray LSB.
- `bin`  out  3  binary value of the last accepted code.
- `dir`  out  1  direction of the last valid step: 1 = up, 0 = down.
- `step_ok`  out  1  one-cycle pulse marking a legal step.
- `err`  out  1  one-cycle pulse marking an illegal transition.
- `lap_done`  out  1  one-cycle pulse when a full upward lap returns to 000.
- `in_sync`  out  1  high while in state TRACK.
- `err_count`  out  ERR_W  saturating count of errors.
- `lap_count`  out  LAP_W  wrapping count of completed laps.

## Operation
- Decode is combinational:
  - `g2b[2] = a`
  - `g2b[1] = a^b`
  - `g2b[0] = a^b^c`
- State machine:
  - **SYNC**: the reset state. Samples wait for code 000; on 000 → TRACK with `last=0` and `run=0`. Nonzero samples are ignored, with no `err`.
  - **TRACK**: each sample has `d = g2b − last` (mod 8).
    - d=0: hold. No pulse.
    - d=1: `step_ok`, `dir=1`, `run++`.
    - d=7: `step_ok`, `dir=0`, `run=0`.
    - Any other d (e.g. 000→010, which is Hamming-1 but d=3): `err`, go to FAULT, `last` unchanged.
  - **FAULT**: samples are ignored until code 000. On 000 → TRACK with `last=0` and `run=0`, no pulse.
- Lap: an up step that lands on bin 0 with `run` reaching 8 pulses `lap_done` and increments `lap_count`, which wraps. `run` then clears. `run` is a 4-bit internal counter.
- `err_count` saturates at all-ones and never wraps.
- On a legal step, `bin` takes the new value. `dir` changes only on a legal step.

## Timing
- Latency: outputs are registered. A sample at edge N is reflected in `bin`, `dir`, pulses and counters after edge N, i.e. valid in cycle N+1.
- Pulses last exactly one cycle and are 0 on any cycle without a qualifying sample.
- Back-to-back `in_valid` samples are legal. Each is evaluated against the `last` value updated by the previous sample.
- Reset values:
  - state SYNC
  - `bin=0`, `dir=0`
  - `step_ok=0`, `err=0`, `lap_done=0`
  - `in_sync=0`
  - `err_count=0`, `lap_count=0`
  - `run=0`, `last=0`
- Reset mid-lap discards progress and requires a fresh 000 to resynchronise.
- `rst_n` low overrides `in_valid` on the same edge.

## Structure
- Shared package `gray_chk_pkg`:
  - state enum `{SYNC, TRACK, FAULT}`
  - function `gray2bin3`
  - constant `LAP_STEPS = 8`
- One natural combinational sub-module: `gray_to_bin3`, which wraps the decode and is reusable by other monitors.
- The remainder is a single sequential process: FSM, `last`, `run`, counters and registered outputs.

## Test plan
- **Full upward lap**: reset, then 000,001,011,010,110,111,101,100,000 on consecutive strobes.
  - 8× `step_ok`, `dir=1`.
  - `bin` goes 0..7,0.
  - `lap_done` once on the final sample; `lap_count=1`, `err_count=0`.
- **Reverse walk**: 000,100,101,111 → 3× `step_ok`, `dir=0`, `bin` 7,6,5, no `lap_done`.
- **Illegal jump**: 000 then 010.
  - `err` pulse, `err_count=1`, `in_sync=0`.
  - A following 011 is ignored.
  - Then 000 → `in_sync=1`, no pulse.
- **Hold and gaps**: 000,001,001,001 with idle cycles between strobes → exactly 1 `step_ok`, no `err`.
- **Pre-sync and mid-lap reset**:
  - 011 after reset → ignored, `in_sync=0`.
  - Reset asserted after 000,001,011 → all outputs 0, and a lap is not credited until a fresh 000 plus 8 up steps.
- **Saturation** (`ERR_W=2`): five illegal jumps, each followed by a resync on 000 → `err_count` reads 3 and stays at 3.
